// File: rtl/param_count_processor.sv
// Parametrised counting processor: COUNT / SUM runs with a start/done handshake.
// Optional PCP_TRISTATE_OUT_EN: out is driven only while out_valid is high.
module param_count_processor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CHECK,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH:0]   sum_nxt;

  // Extra top bit of each sum is the carry out of WIDTH.
  assign a_nxt   = {1'b0, a_q} + STEP_W;
  assign sum_nxt = {1'b0, sum_q} + {1'b0, a_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    sum_d   = sum_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d = limit;
          mode_d  = mode;
          ovf_d   = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        a_d     = '0;
        sum_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = (a_q < limit_q) ? S_EXEC : S_DONE;
      end
      S_EXEC: begin
        if (mode_q) begin
          sum_d = sum_nxt[WIDTH-1:0];
          out_d = sum_nxt[WIDTH-1:0];
          if (sum_nxt[WIDTH]) ovf_d = 1'b1;
        end else begin
          out_d = a_q;
        end
        a_d   = a_nxt[WIDTH-1:0];
        vld_d = 1'b1;
        if (a_nxt[WIDTH]) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      sum_q   <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      sum_q   <= sum_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = vld_q;
  assign ovf       = ovf_q;

`ifdef PCP_TRISTATE_OUT_EN
  assign out = vld_q ? out_q : {WIDTH{1'bz}};
`else
  assign out = out_q;
`endif

endmodule

// File: tb/tb_param_count_processor.sv
// Scoreboard bench: two instances (STEP=1, STEP=100) against a run-level model.
// Random runs with busy-time noise on start/mode/limit.
module tb_param_count_processor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, mode_a, start_b, mode_b;
  logic [7:0] limit_a, limit_b;
  logic       busy_a, vld_a, done_a, ovf_a;
  logic       busy_b, vld_b, done_b, ovf_b;
  logic [7:0] out_a, out_b;

  int n_chk  = 0;
  int n_pass = 0;
  int eq0[$], eq1[$];
  bit dq0[$], dq1[$];
  bit cur = 1'b0;

  logic       busy_x, done_x;
  logic [7:0] out_x;

  always #5 clk = ~clk;

  param_count_processor #(.WIDTH(8), .STEP(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
    .limit(limit_a), .busy(busy_a), .out_valid(vld_a),
    .out(out_a), .done(done_a), .ovf(ovf_a)
  );

  param_count_processor #(.WIDTH(8), .STEP(100)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
    .limit(limit_b), .busy(busy_b), .out_valid(vld_b),
    .out(out_b), .done(done_b), .ovf(ovf_b)
  );

  assign busy_x = cur ? busy_b : busy_a;
  assign done_x = cur ? done_b : done_a;
  assign out_x  = cur ? out_b  : out_a;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic flag(input string nm);
    n_chk++;
    $display("FAIL %s: got unexpected event expected none", nm);
  endtask

  // Monitors: pop an expected result whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld_a) begin
        if (eq0.size() == 0) flag("a_spurious_valid");
        else chk("a_out", {24'd0, out_a}, eq0.pop_front());
      end
      if (done_a) begin
        if (dq0.size() == 0) flag("a_spurious_done");
        else begin
          chk("a_ovf", {31'd0, ovf_a}, {31'd0, dq0.pop_front()});
          chk("a_strobes_left", eq0.size(), 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (vld_b) begin
        if (eq1.size() == 0) flag("b_spurious_valid");
        else chk("b_out", {24'd0, out_b}, eq1.pop_front());
      end
      if (done_b) begin
        if (dq1.size() == 0) flag("b_spurious_done");
        else begin
          chk("b_ovf", {31'd0, ovf_b}, {31'd0, dq1.pop_front()});
          chk("b_strobes_left", eq1.size(), 0);
        end
      end
    end
  end

  // Run-level model: list of results, final overflow, and done edge.
  task automatic model(input bit inst, input bit md, input int lim,
                       output int done_edge, output int last,
                       output int n);
    int  step;
    int  a;
    int  s;
    bit  ov;
    bit  brk;
    step = inst ? 100 : 1;
    a = 0; s = 0; ov = 0; brk = 0; n = 0; last = 0;
    while (a < lim) begin
      int v;
      if (md) begin
        s = s + a;
        if (s > 255) ov = 1;
        s = s % 256;
        v = s;
      end else begin
        v = a;
      end
      if (inst) eq1.push_back(v);
      else eq0.push_back(v);
      last = v;
      n++;
      a = a + step;
      if (a > 255) begin
        ov = 1;
        brk = 1;
        break;
      end
    end
    if (inst) dq1.push_back(ov);
    else dq0.push_back(ov);
    done_edge = brk ? 2 * n + 1 : 2 * n + 2;
  endtask

  task automatic drive(input bit s, input bit m, input logic [7:0] l);
    if (cur) begin
      start_b = s; mode_b = m; limit_b = l;
    end else begin
      start_a = s; mode_a = m; limit_a = l;
    end
  endtask

  task automatic flush();
    eq0.delete(); eq1.delete(); dq0.delete(); dq1.delete();
  endtask

  task automatic run(input bit inst, input bit md, input int lim,
                     input bit noise);
    int de, last, n, d;
    model(inst, md, lim, de, last, n);
    @(negedge clk);
    cur = inst;
    drive(1'b1, md, lim[7:0]);
    @(posedge clk);
    #1;
    drive(1'b0, md, lim[7:0]);
    chk("busy_after_start", {31'd0, busy_x}, 1);
    d = 0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      #1;
      if (noise)
        drive(1'($urandom), 1'($urandom), 8'($urandom));
      if (done_x) begin
        d = k;
        break;
      end
    end
    drive(1'b0, 1'b0, 8'd0);
    if (d == 0) begin
      flag("done_timeout");
      flush();
    end else begin
      chk("done_edge", d, de);
    end
    @(posedge clk);
    #1;
    chk("busy_after_done", {31'd0, busy_x}, 0);
    chk("done_one_cycle", {31'd0, done_x}, 0);
`ifndef PCP_TRISTATE_OUT_EN
    if (n > 0) chk("out_hold", {24'd0, out_x}, last);
`endif
  endtask

  task automatic chk_reset_state(input string nm);
    logic [7:0] eo;
`ifdef PCP_TRISTATE_OUT_EN
    eo = 8'bz;
`else
    eo = 8'd0;
`endif
    chk({nm, "_busy"}, {31'd0, busy_a}, 0);
    chk({nm, "_vld"},  {31'd0, vld_a},  0);
    chk({nm, "_done"}, {31'd0, done_a}, 0);
    chk({nm, "_ovf"},  {31'd0, ovf_a},  0);
    chk({nm, "_out"},  {24'd0, out_a},  {24'd0, eo});
    chk({nm, "_b_busy"}, {31'd0, busy_b}, 0);
  endtask

  initial begin
    int de, last, n;
    rst = 1'b1;
    start_a = 0; mode_a = 0; limit_a = 0;
    start_b = 0; mode_b = 0; limit_b = 0;
    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Abort a limit=10 run while in EXEC.
    model(1'b0, 1'b0, 10, de, last, n);
    @(negedge clk);
    cur = 1'b0;
    drive(1'b1, 1'b0, 8'd10);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'd10);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_state("midrun_reset");
    flush();
    @(negedge clk);
    rst = 1'b0;

    run(1'b0, 1'b0, 10, 1'b0);
    run(1'b0, 1'b1, 10, 1'b0);
    run(1'b0, 1'b0, 0, 1'b0);
    run(1'b0, 1'b1, 0, 1'b0);
    run(1'b1, 1'b0, 255, 1'b0);
    run(1'b0, 1'b1, 30, 1'b1);
    run(1'b1, 1'b1, 255, 1'b1);
    for (int i = 0; i < 24; i++)
      run(1'($urandom), 1'($urandom), int'($urandom_range(0, 40)),
          1'($urandom));
    run(1'b0, 1'b0, 255, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty",
        eq0.size() + eq1.size() + dq0.size() + dq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
